expr_vec_sequencer: RTL

- Controller that sequences one combinational expression datapath (the 12-operand / 90-bit-result blocks in this regression set) through a run of pseudo-random operand vectors.
- Generates operands from a seeded LFSR and drives them on a 60-bit bus. Waits a settle latency, then captures the 90-bit result.
- Folds each result into a 32-bit MISR signature and streams each captured result out over a valid/ready port.
- Sits between the regression testbench top and the expression instance. Its signature is compared across synthesis flows.

---
 rtl/expr_vec_pkg.sv | 27 ++
 rtl/expr_vec_sequencer_if.sv | 28 ++
 rtl/expr_vec_misr.sv | 23 ++
 rtl/expr_vec_sequencer.sv | 101 ++++++++++
 4 files changed

// File: rtl/expr_vec_pkg.sv
// Shared constants and LFSR/MISR step functions for the expression-vector sequencer.
package expr_vec_pkg;

  localparam int OPND_W = 60;
  localparam int RES_W  = 90;

  localparam logic [63:0] LFSR_TAPS = 64'hB000_0000_0000_0001;
  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_DRIVE = 2'd1;
  localparam state_t ST_OUT   = 2'd2;
  localparam state_t ST_FIN   = 2'd3;

  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    return {s[62:0], 1'b0} ^ (s[63] ? LFSR_TAPS : 64'd0);
  endfunction

  // The 90-bit result is folded to 32 bits before entering the shift register.
  function automatic logic [31:0] misr_next(input logic [31:0] s, input logic [RES_W-1:0] r);
    logic [31:0] f;
    f = r[31:0] ^ r[63:32] ^ {6'b0, r[89:64]};
    return {s[30:0], 1'b0} ^ (s[31] ? MISR_POLY : 32'd0) ^ f;
  endfunction

endpackage

// File: rtl/expr_vec_sequencer_if.sv
// Control, operand/result and output-stream bundle between the sequencer and its environment.
interface expr_vec_sequencer_if #(parameter int IDX_W = 16);
  import expr_vec_pkg::*;

  logic                start;
  logic [31:0]         seed;
  logic [IDX_W-1:0]    num_vec;
  logic                busy;
  logic                done;
  logic [OPND_W-1:0]   opnd;
  logic [RES_W-1:0]    res;
  logic                out_valid;
  logic                out_ready;
  logic [RES_W-1:0]    out_data;
  logic [IDX_W-1:0]    out_idx;
  logic [31:0]         signature;

  modport master (
    input  start, seed, num_vec, res, out_ready,
    output busy, done, opnd, out_valid, out_data, out_idx, signature
  );

  modport slave (
    output start, seed, num_vec, res, out_ready,
    input  busy, done, opnd, out_valid, out_data, out_idx, signature
  );

endinterface

// File: rtl/expr_vec_misr.sv
// 32-bit signature register: cleared at the start of a run, folded once per captured result.
module expr_vec_misr
  import expr_vec_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [RES_W-1:0] res,
  output logic [31:0]      signature
);

  always_ff @(posedge clk) begin
    if (reset) begin
      signature <= 32'd0;
    end else if (clear) begin
      signature <= 32'd0;
    end else if (en) begin
      signature <= misr_next(signature, res);
    end
  end

endmodule

// File: rtl/expr_vec_sequencer.sv
// Drives LFSR operand vectors into an expression datapath, captures each result after
// LAT settle cycles, streams it out over valid/ready and folds it into a MISR signature.
module expr_vec_sequencer
  import expr_vec_pkg::*;
#(
  parameter int LAT   = 1,
  parameter int IDX_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  expr_vec_sequencer_if.master bus
);

  state_t           state;
  logic [63:0]      lfsr;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] nvec;
  logic [3:0]       cnt;
  logic [RES_W-1:0] out_data_r;
  logic [IDX_W-1:0] out_idx_r;

  logic accept;
  logic capture;
  logic handshake;
  logic last_vec;

  assign accept    = (state == ST_IDLE) && bus.start;
  assign capture   = (state == ST_DRIVE) && (cnt == 4'(LAT - 1));
  assign handshake = (state == ST_OUT) && bus.out_ready;
  assign last_vec  = (idx == nvec - IDX_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      lfsr       <= 64'd0;
      idx        <= '0;
      nvec       <= '0;
      cnt        <= 4'd0;
      out_data_r <= '0;
      out_idx_r  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            nvec  <= bus.num_vec;
            lfsr  <= {~bus.seed, bus.seed};
            idx   <= '0;
            cnt   <= 4'd0;
            state <= (bus.num_vec == '0) ? ST_FIN : ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (capture) begin
            out_data_r <= bus.res;
            out_idx_r  <= idx;
            cnt        <= 4'd0;
            state      <= ST_OUT;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_OUT: begin
          // A stalled consumer freezes everything, including the LFSR, so the
          // signature is independent of backpressure.
          if (handshake) begin
            if (last_vec) begin
              state <= ST_FIN;
            end else begin
              idx   <= idx + IDX_W'(1);
              lfsr  <= lfsr_next(lfsr);
              state <= ST_DRIVE;
            end
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  expr_vec_misr u_misr (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept),
    .en        (capture),
    .res       (bus.res),
    .signature (bus.signature)
  );

  assign bus.opnd      = lfsr[OPND_W-1:0];
  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = (state == ST_FIN);
  assign bus.out_valid = (state == ST_OUT);
  assign bus.out_data  = out_data_r;
  assign bus.out_idx   = out_idx_r;

endmodule
